// File: rtl/div12u_pkg.sv
// Shared types and constants for the sequential restoring divider.
// DIV12U_SAT_EN selects the saturated error quotient.
package div12u_pkg;

  localparam int DIV_W = 12;
  localparam int CNT_W = $clog2(DIV_W);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  localparam logic [DIV_W-1:0] SAT_QUOT = {DIV_W{1'b1}};

endpackage

// File: rtl/div12u_if.sv
// Operand and result handshake bundle for div12u_seq.
// Macro DIV12U_SAT_EN does not affect this file.
interface div12u_if #(
  parameter int W = div12u_pkg::DIV_W
);

  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] in_dividend;
  logic [W-1:0]   in_divisor;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_quot;
  logic [W-1:0]   out_rem;
  logic           out_err;

  modport master (
    output in_valid,
    output in_dividend,
    output in_divisor,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_quot,
    input  out_rem,
    input  out_err
  );

  modport slave (
    input  in_valid,
    input  in_dividend,
    input  in_divisor,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_quot,
    output out_rem,
    output out_err
  );

endinterface

// File: rtl/div12u_step.sv
// One combinational restoring-division iteration.
// Macro DIV12U_SAT_EN does not affect this file.
module div12u_step #(
  parameter int W = div12u_pkg::DIV_W
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] div_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0] trial;

  // W+1-bit trial; the W-bit difference is exact whenever trial >= divisor
  always_comb begin
    trial = {rem_i, bit_i};
    q_o   = (trial >= {1'b0, div_i});
    rem_o = q_o ? (trial[W-1:0] - div_i) : trial[W-1:0];
  end

endmodule

// File: rtl/div12u_seq.sv
// Sequential restoring unsigned divider, 2W / W bits, one bit per clock.
// DIV12U_SAT_EN: error quotient saturates to all ones instead of zero.
module div12u_seq
  import div12u_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic     clk,
  input  logic     rst,
  div12u_if.slave  bus,
  output logic     busy
);

  localparam int CW = $clog2(W);

`ifdef DIV12U_SAT_EN
  localparam logic [W-1:0] ERR_QUOT = W'(SAT_QUOT);
`else
  localparam logic [W-1:0] ERR_QUOT = '0;
`endif

  state_e        state_q, state_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          pend_q, pend_d;

  logic [W-1:0]  hi, lo;
  logic          ovf;
  logic [W-1:0]  step_rem;
  logic          step_q;

  assign hi  = bus.in_dividend[2*W-1:W];
  assign lo  = bus.in_dividend[W-1:0];
  assign ovf = (bus.in_divisor == '0) || (hi >= bus.in_divisor);

  div12u_step #(.W(W)) u_step (
    .rem_i (rem_q),
    .bit_i (sh_q[W-1]),
    .div_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      sh_q    <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sh_q    <= sh_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

  // sh_q shifts dividend bits out of the top and quotient bits in at the bottom
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sh_d    = sh_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    pend_d  = pend_q;
    unique case (state_q)
      IDLE: begin
        if (pend_q) begin
          pend_d  = 1'b0;
          state_d = DONE;
        end else if (bus.in_valid) begin
          dvs_d = bus.in_divisor;
          if (ovf) begin
            // error result parks one cycle so it appears at E+1
            pend_d = 1'b1;
            err_d  = 1'b1;
            rem_d  = '0;
            sh_d   = ERR_QUOT;
          end else begin
            err_d   = 1'b0;
            rem_d   = hi;
            sh_d    = lo;
            cnt_d   = CW'(W-1);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        rem_d = step_rem;
        sh_d  = {sh_q[W-2:0], step_q};
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE) && !pend_q && !rst;
    bus.out_valid = (state_q == DONE);
    bus.out_quot  = bus.out_valid ? sh_q : '0;
    bus.out_rem   = bus.out_valid ? rem_q : '0;
    bus.out_err   = bus.out_valid && err_q;
    busy          = (state_q == BUSY);
  end

endmodule

// File: doc/div12u_seq.md
Name: div12u_seq

Overview:
- Sequential restoring unsigned divider: 2W-bit dividend by W-bit divisor gives a W-bit quotient and a W-bit remainder.
- Inverse companion to the 12x12 unsigned multipliers in the library; recovers an operand from a product, and serves as the exact reference for error evaluation.
- Produces one quotient bit per clock.
- Valid/ready handshake on both the input and the output side.

Parameters:
- W, 12, divisor/quotient/remainder width; dividend is 2W bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- in_dividend  in  2W  unsigned dividend.
- in_divisor  in  W  unsigned divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_quot  out  W  quotient.
- out_rem  out  W  remainder.
- out_err  out  1  divide-by-zero or quotient overflow.
- busy  out  1  iteration in progress.

Behaviour:
- Reset (async, active-high): state=IDLE; out_valid=0, out_quot=0, out_rem=0, out_err=0, busy=0; in_ready=1 after reset deassertion.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - Acceptance edge E is the edge with in_valid&in_ready.
  - Error check at E: divisor==0, or dividend[2W-1:W] >= divisor. On error, go to DONE with out_err=1 and skip BUSY.
  - Otherwise: load partial remainder = dividend[2W-1:W], shift register = dividend[W-1:0], counter = W-1, then go to BUSY.
  - Operands are sampled only at E; later changes on the input bus are ignored.
- BUSY:
  - Each edge performs one restoring step: shift remainder left by 1, bringing in the next dividend bit MSB-first.
  - If the (W+1)-bit trial value >= divisor, subtract the divisor and shift in quotient bit 1; otherwise shift in 0.
  - When counter==0, go to DONE; otherwise decrement the counter.
  - busy=1 and in_ready=0 throughout.
- Latency:
  - Normal case: out_valid goes high at edge E+W (12 edges for W=12).
  - Error case: out_valid goes high at edge E+1.
- DONE:
  - out_valid=1; out_quot, out_rem and out_err held stable until out_valid&out_ready.
  - On that edge: out_valid=0, go to IDLE. in_ready stays 0 in DONE (no overlap).
  - Next acceptance is possible at the edge following the return to IDLE.
- Error result, macro off: out_quot=0, out_rem=0, out_err=1.
- Arithmetic:
  - Exact for all non-error inputs: dividend = out_quot*divisor + out_rem, with out_rem < divisor.
  - The trial subtraction uses W+1 bits so no intermediate value overflows.
- Boundaries:
  - Maximum input 0xFFE001/0xFFF must not be flagged as overflow.
  - Dividend 0 gives quot=0, rem=0 with full W-cycle latency.
  - out_ready held high while entering DONE: the result is consumed on the first DONE edge.
- Reset mid-operation (any state): immediate return to IDLE with all outputs at reset values; the in-flight result is discarded and never presented.

Optional Feature:
- DIV12U_SAT_EN
- Defined: on error, out_quot={W{1'b1}} (saturated) and out_rem=0, with out_err=1. Divide-by-zero and overflow are both saturated.
- Undefined: on error, out_quot=0 and out_rem=0, with out_err=1.
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package div12u_pkg:
  - W default constant;
  - state enum (IDLE, BUSY, DONE);
  - counter width localparam $clog2(W);
  - saturation constant.
- One sub-module, div12u_step: combinational single restoring iteration.
  - Inputs: remainder, incoming bit, divisor.
  - Outputs: next remainder, quotient bit.
  - Instantiated once; the top level holds the registers and FSM.

Test Plan:
- 0x000064 / 0x007 -> out_quot=0x00E, out_rem=0x002, out_err=0; out_valid exactly 12 edges after acceptance.
- Round trip: 0x0C33B4 (=0xABC*0x123) / 0x123 -> out_quot=0xABC, out_rem=0; then 0xFFE001 / 0xFFF -> 0xFFF, rem 0, no error.
- Divisor 0x000 with dividend 0x001234 -> out_err=1 one edge after acceptance. Macro off: quot=0x000. Macro on: quot=0xFFF. rem=0 in both builds.
- Overflow 0x100000 / 0x0FF -> out_err=1, no BUSY cycles, busy stays 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> out_valid drops next edge and in_ready rises.
- Reset asserted at the 6th BUSY edge -> out_valid, busy and out_quot return to 0 immediately; a following 0x000064/0x007 completes correctly.
